// File: rtl/prt_egress_scheduler_pkg.sv
// Shared types and default sizing for the PRT egress scheduler.
// The packed byte type is the same layout the PRT uses on its read port.
package prt_pkg;
    localparam int TABLE_SIZE = 8;
    localparam int IDX_W      = $clog2(TABLE_SIZE);
    localparam int DATA_SIZE  = 8;
    localparam int NUM_PORTS  = 4;
    localparam int RD_TIMEOUT = 16;

    typedef enum logic [1:0] {IDLE, START, STREAM, FLUSH} sched_state_e;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data_byte;
        logic                 is_last_byte;
    } prt_byte_t;
endpackage

// File: rtl/prt_egress_scheduler_if.sv
// Bundle of every non-clock/reset signal of the egress scheduler.
// master = scheduler side, slave = PRT / egress port / frame-done side.
interface prt_egress_scheduler_if #(
    parameter int IDX_W     = prt_pkg::IDX_W,
    parameter int NUM_PORTS = prt_pkg::NUM_PORTS,
    parameter int DATA_SIZE = prt_pkg::DATA_SIZE
);
    logic                 done_valid;
    logic [IDX_W-1:0]     done_slot;
    logic                 prt_start_rd;
    logic [IDX_W-1:0]     prt_start_slot;
    logic                 prt_rd_en;
    logic                 prt_rd_valid;
    logic [DATA_SIZE-1:0] prt_rd_data;
    logic                 prt_rd_last;
    logic                 prt_inval_valid;
    logic [IDX_W-1:0]     prt_inval_slot;
    logic [NUM_PORTS-1:0] port_req;
    logic [NUM_PORTS-1:0] port_gnt;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_last;
    logic                 out_ready;
    logic [IDX_W:0]       q_count;
    logic                 q_overflow;

    modport master (
        input  done_valid, done_slot, prt_rd_valid, prt_rd_data, prt_rd_last,
               port_req, out_ready,
        output prt_start_rd, prt_start_slot, prt_rd_en, prt_inval_valid,
               prt_inval_slot, port_gnt, out_valid, out_data, out_last,
               q_count, q_overflow
    );

    modport slave (
        output done_valid, done_slot, prt_rd_valid, prt_rd_data, prt_rd_last,
               port_req, out_ready,
        input  prt_start_rd, prt_start_slot, prt_rd_en, prt_inval_valid,
               prt_inval_slot, port_gnt, out_valid, out_data, out_last,
               q_count, q_overflow
    );
endinterface

// File: rtl/prt_egress_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module prt_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        idx
);
    logic          found;
    logic [PW-1:0] sel;
    int            pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        pos   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            sel = PW'(pos);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end
endmodule

// File: rtl/prt_egress_scheduler.sv
// PRT read-side sequencer: ready-slot FIFO, round-robin port grant,
// start/read handshake with timeout, and byte streaming to the granted port.
module prt_egress_scheduler #(
    parameter int TABLE_SIZE = prt_pkg::TABLE_SIZE,
    parameter int IDX_W      = prt_pkg::IDX_W,
    parameter int NUM_PORTS  = prt_pkg::NUM_PORTS,
    parameter int DATA_SIZE  = prt_pkg::DATA_SIZE,
    parameter int RD_TIMEOUT = prt_pkg::RD_TIMEOUT
) (
    input logic                    clk,
    input logic                    rst,
    prt_egress_scheduler_if.master bus
);
    import prt_pkg::*;

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [IDX_W:0] Q_FULL = (IDX_W+1)'(TABLE_SIZE);

    sched_state_e state, state_d;

    logic [IDX_W-1:0] q_mem [TABLE_SIZE];
    logic [IDX_W-1:0] wr_ptr, rd_ptr;
    logic [IDX_W:0]   q_cnt;
    logic             q_full, q_pop, q_push, q_drop, q_ovf;

    logic [NUM_PORTS-1:0] arb_gnt, gnt;
    logic [PW-1:0]        arb_idx, gnt_idx, rr_ptr;
    logic [IDX_W-1:0]     cur_slot;

    logic          rd_pend, last_seen, aborted, tmo_hit, rd_take, xfer;
    logic          start_rd, rd_en;
    logic [TW-1:0] tmo_cnt;
    prt_byte_t     obuf;
    logic          obuf_v;

    logic             inval_v, hold_v;
    logic [IDX_W-1:0] inval_slot, hold_slot;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(TABLE_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    prt_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
        .req (bus.port_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign q_full  = (q_cnt == Q_FULL);
    assign q_pop   = (state == IDLE) && (q_cnt != '0) && (|bus.port_req);
    assign q_push  = bus.done_valid && (!q_full || q_pop);
    assign q_drop  = bus.done_valid && q_full && !q_pop;
    assign xfer    = obuf_v && bus.out_ready;
    assign rd_take = bus.prt_rd_valid && rd_pend;
    assign tmo_hit = rd_pend && !bus.prt_rd_valid && (tmo_cnt == TW'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d  = state;
        start_rd = 1'b0;
        rd_en    = 1'b0;
        case (state)
            IDLE:   if (q_pop) state_d = START;
            START: begin
                start_rd = 1'b1;
                state_d  = STREAM;
            end
            STREAM: begin
                rd_en = !rd_pend && !last_seen && !aborted && (!obuf_v || bus.out_ready);
                if ((xfer && obuf.is_last_byte) || (aborted && !obuf_v))
                    state_d = FLUSH;
            end
            FLUSH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slot storage needs no reset; occupancy is tracked by q_cnt.
    always_ff @(posedge clk) begin
        if (q_push) q_mem[wr_ptr] <= bus.done_slot;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            q_ovf  <= 1'b0;
        end else begin
            q_ovf <= q_drop;
            if (q_push) wr_ptr <= ptr_inc(wr_ptr);
            if (q_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (q_push && !q_pop)      q_cnt <= q_cnt + 1'b1;
            else if (!q_push && q_pop) q_cnt <= q_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            cur_slot <= '0;
        end else begin
            if (q_pop) begin
                gnt      <= arb_gnt;
                gnt_idx  <= arb_idx;
                cur_slot <= q_mem[rd_ptr];
            end
            if (state == STREAM && state_d == FLUSH) gnt <= '0;
            if (state == FLUSH)
                rr_ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // One outstanding read at a time; a timeout abandons the rest of the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend   <= 1'b0;
            last_seen <= 1'b0;
            aborted   <= 1'b0;
            tmo_cnt   <= '0;
            obuf      <= '0;
            obuf_v    <= 1'b0;
        end else if (state == START) begin
            rd_pend   <= 1'b0;
            last_seen <= 1'b0;
            aborted   <= 1'b0;
            obuf_v    <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_pend <= 1'b1;
                tmo_cnt <= '0;
            end else if (rd_take) begin
                rd_pend <= 1'b0;
            end else if (tmo_hit) begin
                rd_pend <= 1'b0;
                aborted <= 1'b1;
            end else if (rd_pend) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (rd_take) begin
                obuf.data_byte    <= bus.prt_rd_data;
                obuf.is_last_byte <= bus.prt_rd_last;
                obuf_v            <= 1'b1;
                if (bus.prt_rd_last) last_seen <= 1'b1;
            end else if (xfer) begin
                obuf_v <= 1'b0;
            end else if (tmo_hit && obuf_v) begin
                obuf.is_last_byte <= 1'b1;
            end
        end
    end

    // Timeout invalidate wins; a colliding overflow invalidate waits in hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inval_v    <= 1'b0;
            inval_slot <= '0;
            hold_v     <= 1'b0;
            hold_slot  <= '0;
        end else if (tmo_hit) begin
            inval_v    <= 1'b1;
            inval_slot <= cur_slot;
            if (q_drop) begin
                hold_v    <= 1'b1;
                hold_slot <= bus.done_slot;
            end
        end else if (hold_v) begin
            inval_v    <= 1'b1;
            inval_slot <= hold_slot;
            if (q_drop) hold_slot <= bus.done_slot;
            else        hold_v    <= 1'b0;
        end else if (q_drop) begin
            inval_v    <= 1'b1;
            inval_slot <= bus.done_slot;
        end else begin
            inval_v    <= 1'b0;
        end
    end

    assign bus.prt_start_rd    = start_rd;
    assign bus.prt_start_slot  = cur_slot;
    assign bus.prt_rd_en       = rd_en;
    assign bus.prt_inval_valid = inval_v;
    assign bus.prt_inval_slot  = inval_slot;
    assign bus.port_gnt        = gnt;
    assign bus.out_valid       = obuf_v;
    assign bus.out_data        = obuf.data_byte;
    assign bus.out_last        = obuf_v & obuf.is_last_byte;
    assign bus.q_count         = q_cnt;
    assign bus.q_overflow      = q_ovf;
endmodule

// File: tb/tb_prt_egress_scheduler.sv
// Directed bench for prt_egress_scheduler with a PRT read model and a
// byte scoreboard filled when frames are queued and drained by the monitor.
module tb_prt_egress_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prt_egress_scheduler_if bus ();

    prt_egress_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    // PRT model / monitor state
    int         rd_lat = 1, frame_len = 3, withhold_slot = -1;
    int         req_cnt = 0, resp_cnt = 0, n_start = 0, seen_start = 0;
    int         byte_i = 0, lat_cnt = 0;
    logic [2:0] open_slot = '0;
    int         cyc = 0, last_rd_en_cyc = 0, inval_gap = 0;
    int         n_inval = 0, n_ovf = 0, n_stall = 0;
    logic [2:0] inval_slot_seen = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bval(input int s, input int k);
        return 8'(s * 16 + k + 1);
    endfunction

    task automatic push_frame(input int s, input int len, input logic [3:0] g, input int nb);
        exp_t e;
        for (int k = 0; k < nb; k++) begin
            e.gnt  = g;
            e.data = bval(s, k);
            e.last = (k == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic enq(input int s);
        @(posedge clk); #2;
        bus.done_valid = 1'b1;
        bus.done_slot  = 3'(s);
        @(posedge clk); #2;
        bus.done_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.port_gnt == 4'b0) break;
        end
        chk(tag, i < budget, 1'b1);
    endtask

    // PRT read responder: answers each prt_rd_en after rd_lat cycles.
    initial begin
        bus.prt_rd_valid = 1'b0;
        bus.prt_rd_data  = '0;
        bus.prt_rd_last  = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.prt_rd_valid = 1'b0;
            bus.prt_rd_last  = 1'b0;
            if (!rst) begin
                resp_cnt = 0; lat_cnt = 0; byte_i = 0; seen_start = n_start;
            end else begin
                if (seen_start != n_start) begin
                    seen_start = n_start;
                    byte_i     = 0;
                end
                if (resp_cnt != req_cnt) begin
                    lat_cnt++;
                    if (lat_cnt >= rd_lat) begin
                        lat_cnt = 0;
                        resp_cnt++;
                        if (!(int'(open_slot) == withhold_slot && byte_i == 1)) begin
                            bus.prt_rd_valid = 1'b1;
                            bus.prt_rd_data  = bval(int'(open_slot), byte_i);
                            bus.prt_rd_last  = (byte_i == frame_len - 1);
                        end
                        byte_i++;
                    end
                end
            end
        end
    end

    // Mid-cycle monitor: protocol checks, scoreboard drain, event counters.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            req_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.prt_start_rd) begin
                n_start++;
                open_slot = bus.prt_start_slot;
            end
            if (bus.prt_rd_en) begin
                chk("rd_en_while_outstanding", req_cnt != resp_cnt, 1'b0);
                req_cnt++;
                last_rd_en_cyc = cyc;
            end
            if (bus.prt_inval_valid) begin
                n_inval++;
                inval_slot_seen = bus.prt_inval_slot;
                inval_gap       = cyc - last_rd_en_cyc;
            end
            if (bus.q_overflow) n_ovf++;
            if (bus.out_valid && prev_stall) begin
                n_stall++;
                chk("stall_data_stable", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("unexpected_byte", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                    chk("port_gnt", bus.port_gnt, e.gnt);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_start, base_inval, base_stall;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.done_valid = 1'b0;
        bus.done_slot  = '0;
        bus.port_req   = '0;
        bus.out_ready  = 1'b1;
        #3 rst = 1'b0;
        #20;
        chk("rst_port_gnt",  bus.port_gnt, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_q_count",   bus.q_count, 0);
        chk("rst_start_rd",  bus.prt_start_rd, 0);
        chk("rst_inval",     bus.prt_inval_valid, 0);
        @(posedge clk); #2 rst = 1'b1;

        // Two frames, two ports: slot 2 -> port 0, slot 5 -> port 1
        base_start = n_start;
        bus.port_req = 4'b0011;
        frame_len = 3;
        push_frame(2, 3, 4'b0001, 3);
        push_frame(5, 3, 4'b0010, 3);
        enq(2);
        enq(5);
        drain("t1_drain", 200);
        chk("t1_start_pulses", n_start - base_start, 2);

        // Single port with back-pressure pattern 1,0,0,1
        base_stall = n_stall;
        bus.port_req = 4'b0100;
        frame_len = 4;
        push_frame(1, 4, 4'b0100, 4);
        enq(1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            bus.out_ready = pat[i % 4];
            if (sb.size() == 0 && bus.port_gnt == 4'b0) break;
        end
        bus.out_ready = 1'b1;
        drain("t2_drain", 50);
        chk("t2_stall_seen", n_stall > base_stall, 1'b1);

        // Fill queue with no requester, ninth entry overflows
        bus.port_req = 4'b0000;
        for (int s = 0; s < 8; s++) enq(s);
        chk("t3_q_full", bus.q_count, 8);
        enq(3);
        @(negedge clk);
        chk("t3_q_overflow", bus.q_overflow, 1'b1);
        chk("t3_inval_valid", bus.prt_inval_valid, 1'b1);
        chk("t3_inval_slot", bus.prt_inval_slot, 3);
        chk("t3_q_count", bus.q_count, 8);
        repeat (3) @(negedge clk);
        chk("t3_ovf_once", n_ovf, 1);

        // Full queue: pop and done_valid in the same cycle is accepted
        frame_len = 2;
        for (int s = 0; s < 8; s++) push_frame(s, 2, 4'b1000, 2);
        push_frame(6, 2, 4'b1000, 2);
        @(posedge clk); #2;
        bus.port_req   = 4'b1000;
        bus.done_valid = 1'b1;
        bus.done_slot  = 3'd6;
        @(posedge clk); #2;
        bus.done_valid = 1'b0;
        @(negedge clk);
        chk("t4_q_count", bus.q_count, 8);
        chk("t4_no_overflow", bus.q_overflow, 1'b0);
        drain("t4_drain", 400);
        chk("t4_ovf_total", n_ovf, 1);
        chk("t4_q_empty", bus.q_count, 0);

        // Second read of slot 4 never answered -> timeout, then slot 5 served
        base_inval = n_inval;
        bus.port_req  = 4'b0001;
        frame_len     = 3;
        withhold_slot = 4;
        push_frame(4, 3, 4'b0001, 1);
        push_frame(5, 3, 4'b0001, 3);
        enq(4);
        enq(5);
        drain("t5_drain", 300);
        withhold_slot = -1;
        chk("t5_inval_count", n_inval - base_inval, 1);
        chk("t5_inval_slot", inval_slot_seen, 4);
        chk("t5_timeout_gap", inval_gap >= 16 && inval_gap <= 18, 1'b1);

        // Asynchronous reset in the middle of a stalled frame
        bus.port_req  = 4'b0010;
        bus.out_ready = 1'b0;
        rd_lat = 3;
        enq(2);
        enq(3);
        begin
            int i;
            for (i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.out_valid) break;
            end
            chk("t6_stream_started", i < 60, 1'b1);
        end
        chk("t6_q_before_rst", bus.q_count, 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_port_gnt",  bus.port_gnt, 0);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_out_data",  bus.out_data, 0);
        chk("t6_rst_out_last",  bus.out_last, 0);
        chk("t6_rst_rd_en",     bus.prt_rd_en, 0);
        chk("t6_rst_start_rd",  bus.prt_start_rd, 0);
        chk("t6_rst_q_count",   bus.q_count, 0);
        chk("t6_rst_q_ovf",     bus.q_overflow, 0);
        chk("t6_rst_inval",     bus.prt_inval_valid, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        rd_lat        = 1;
        bus.out_ready = 1'b1;
        bus.port_req  = 4'b1111;
        push_frame(7, 3, 4'b0001, 3);
        enq(7);
        drain("t6_drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
